// File: rtl/parity_check_arbiter_if.sv
// Request/result handshake bundle for the shared parity checker.
// The master side produces requests and consumes results.
interface parity_check_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_parity;
  logic [N_REQ-1:0]        req_ready;
  logic                    res_valid;
  logic                    res_ready;
  logic [ID_W-1:0]         res_id;
  logic                    res_error;

  modport master (
    output req_valid, req_data, req_parity, res_ready,
    input  req_ready, res_valid, res_id, res_error
  );

  modport slave (
    input  req_valid, req_data, req_parity, res_ready,
    output req_ready, res_valid, res_id, res_error
  );
endinterface

// File: rtl/parity_check_arbiter.sv
// Round-robin shared even-parity checker with tagged results
// and a saturating, clearable error counter.
module parity_check_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_check_arbiter_if.slave bus,
  input  logic                 clear_count,
  output logic [CNT_W-1:0]     err_count,
  output logic                 busy
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RESULT
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                par_q, par_d;
  logic                res_valid_q, res_valid_d;
  logic [ID_W-1:0]     res_id_q, res_id_d;
  logic                res_error_q, res_error_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                found;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     cand;
  logic [N_REQ-1:0]    ready_c;
  logic                inc;

  // First valid requester after last_grant, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % N_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
  end

  always_comb begin
    ready_c = '0;
    if (!rst && state_q == IDLE && found) begin
      ready_c[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gid_d       = gid_q;
    data_d      = data_q;
    par_d       = par_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_error_d = res_error_q;
    inc         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gid_d   = gnt_id;
          last_d  = gnt_id;
          data_d  = bus.req_data[int'(gnt_id)*DATA_W +: DATA_W];
          par_d   = bus.req_parity[gnt_id];
          state_d = CHECK;
        end
      end
      CHECK: begin
        res_error_d = ^{par_q, data_q};
        res_id_d    = gid_q;
        res_valid_d = 1'b1;
        state_d     = RESULT;
      end
      RESULT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          inc         = res_error_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = '0;
    end else if (inc && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(N_REQ - 1);
      gid_q       <= '0;
      data_q      <= '0;
      par_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_error_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gid_q       <= gid_d;
      data_q      <= data_d;
      par_q       <= par_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_error_q <= res_error_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_error = res_error_q;
  assign err_count     = cnt_q;
  assign busy          = (state_q != IDLE);

endmodule
